// File: rtl/upsample.sv
// Interpolating sample-rate converter: expands a low-rate stream by N back to
// the 48 kHz output tick using zero-stuffing, zero-order hold or linear ramps.
module upsample #(
    parameter int unsigned DW = 18,
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] Nfreq,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] datain,
    input  logic          endatain,
    input  logic          en48k,
    input  logic          clrflags,
    output logic [DW-1:0] dataout,
    output logic          endataout,
    output logic          underrun,
    output logic          overrun
);

    // delta needs one extra bit; reciprocal is a 17-bit Q16 constant
    localparam int unsigned NW    = DW + 1;
    localparam int unsigned RW    = 17;
    localparam int unsigned PW    = NW + RW;
    localparam int unsigned SHIFT = 16;

    localparam logic [1:0] MODE_ZERO = 2'd0;
    localparam logic [1:0] MODE_LIN  = 2'd2;

    // round(65536/N); N=1 never ramps, so its entry is unused
    function automatic logic [RW-1:0] recip(input logic [CW-1:0] n);
        logic [RW-1:0] r;
        case (32'(n))
            2:       r = 17'd32768;
            3:       r = 17'd21845;
            4:       r = 17'd16384;
            5:       r = 17'd13107;
            6:       r = 17'd10923;
            7:       r = 17'd9362;
            8:       r = 17'd8192;
            9:       r = 17'd7282;
            10:      r = 17'd6554;
            11:      r = 17'd5958;
            12:      r = 17'd5461;
            13:      r = 17'd5041;
            14:      r = 17'd4681;
            15:      r = 17'd4369;
            default: r = 17'd65536;
        endcase
        return r;
    endfunction

    logic [CW-1:0] cnt,        cnt_next;
    logic [DW-1:0] pend,       pend_next;
    logic          pend_valid, pend_valid_next;
    logic [DW-1:0] last,       last_next;
    logic [DW-1:0] acc,        acc_next;
    logic [DW-1:0] step,       step_next;
    logic [1:0]    mode_r,     mode_r_next;
    logic [DW-1:0] dataout_next;
    logic          underrun_next;
    logic          overrun_next;

    logic          frame_start;
    logic [CW-1:0] n_eff;
    logic [DW-1:0] src;
    logic [NW-1:0] delta;
    logic [PW-1:0] prod;
    logic [DW-1:0] step_new;
    logic [DW-1:0] acc_inc;
    logic [DW-1:0] out_val;
    logic          und_set;
    logic          ovr_set;

    // frame-start source selection and linear-ramp step computation
    always_comb begin
        n_eff       = (Nfreq == '0) ? CW'(1) : Nfreq;
        frame_start = en48k && (cnt == '0);

        // a same-cycle input bypasses the pending register; nothing at all repeats L
        if (endatain) begin
            src = datain;
        end else if (pend_valid) begin
            src = pend;
        end else begin
            src = last;
        end

        delta = {src[DW-1], src} - {last[DW-1], last};
        // modular product: only the low bits feeding the truncated step matter
        prod     = {{RW{delta[NW-1]}}, delta} * {{NW{1'b0}}, recip(n_eff)};
        step_new = DW'(prod >> SHIFT);
        acc_inc  = acc + step;
    end

    // output sample for the current tick
    always_comb begin
        out_val = last;
        if (frame_start) begin
            case (mode)
                MODE_LIN: out_val = last;
                default:  out_val = src;
            endcase
        end else begin
            case (mode_r)
                MODE_ZERO: out_val = '0;
                MODE_LIN:  out_val = acc_inc;
                default:   out_val = last;
            endcase
        end
    end

    // next-state for counter, capture path, ramp state and sticky flags
    always_comb begin
        cnt_next        = cnt;
        pend_next       = pend;
        pend_valid_next = pend_valid;
        last_next       = last;
        acc_next        = acc;
        step_next       = step;
        mode_r_next     = mode_r;
        dataout_next    = dataout;
        und_set         = 1'b0;
        ovr_set         = 1'b0;

        if (frame_start) begin
            cnt_next        = n_eff - CW'(1);
            mode_r_next     = mode;
            pend_valid_next = 1'b0;
            und_set         = !endatain && !pend_valid;
            last_next       = src;
            acc_next        = last;
            step_next       = step_new;
        end else begin
            if (en48k) begin
                cnt_next = cnt - CW'(1);
                acc_next = acc_inc;
            end
            if (endatain) begin
                ovr_set         = pend_valid;
                pend_next       = datain;
                pend_valid_next = 1'b1;
            end
        end

        if (en48k) begin
            dataout_next = out_val;
        end

        // a set event in the same cycle wins over clrflags
        underrun_next = und_set || (underrun && !clrflags);
        overrun_next  = ovr_set || (overrun && !clrflags);
    end

    // state and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            last       <= '0;
            acc        <= '0;
            step       <= '0;
            mode_r     <= '0;
            dataout    <= '0;
            endataout  <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            pend       <= pend_next;
            pend_valid <= pend_valid_next;
            last       <= last_next;
            acc        <= acc_next;
            step       <= step_next;
            mode_r     <= mode_r_next;
            dataout    <= dataout_next;
            endataout  <= en48k;
            underrun   <= underrun_next;
            overrun    <= overrun_next;
        end
    end

endmodule

// File: tb/tb_upsample.sv
// Bench for upsample: directed scenarios plus random traffic, checked by a
// frame-level reference model through an expected-output queue.
module tb_upsample;

    localparam int unsigned DW = 18;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [CW-1:0] Nfreq;
    logic [1:0]    mode;
    logic [DW-1:0] datain;
    logic          endatain;
    logic          en48k;
    logic          clrflags;
    logic [DW-1:0] dataout;
    logic          endataout;
    logic          underrun;
    logic          overrun;

    always #5 clock = ~clock;

    upsample #(.DW(DW), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .Nfreq     (Nfreq),
        .mode      (mode),
        .datain    (datain),
        .endatain  (endatain),
        .en48k     (en48k),
        .clrflags  (clrflags),
        .dataout   (dataout),
        .endataout (endataout),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    typedef struct {
        int val;
        bit und;
        bit ovr;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerr    = 0;

    // reference model: pending samples, remaining outputs of current frame
    int   m_pend[$];
    int   m_frame[$];
    int   m_last = 0;
    bit   m_und  = 1'b0;
    bit   m_ovr  = 1'b0;

    function automatic int wrap(input longint v);
        longint t;
        t = v & ((longint'(1) << DW) - 1);
        if (t >= (longint'(1) << (DW - 1))) t = t - (longint'(1) << DW);
        return int'(t);
    endfunction

    function automatic longint recip_of(input int n);
        return (longint'(65536) + longint'(n / 2)) / longint'(n);
    endfunction

    task automatic model_edge(input bit rst, input bit e, input bit ei, input int d,
                              input bit c, input int nf, input int md);
        bit     us;
        bit     os;
        int     s;
        int     n;
        longint stp;
        exp_t   x;
        us = 1'b0;
        os = 1'b0;
        if (rst) begin
            m_pend.delete();
            m_frame.delete();
            m_last = 0;
            m_und  = 1'b0;
            m_ovr  = 1'b0;
            return;
        end
        if (e && m_frame.size() == 0) begin
            n = (nf == 0) ? 1 : nf;
            if (ei) s = d;
            else if (m_pend.size() > 0) s = m_pend[0];
            else begin
                s  = m_last;
                us = 1'b1;
            end
            m_pend.delete();
            stp = ((longint'(s) - longint'(m_last)) * recip_of(n)) >>> 16;
            for (int k = 0; k < n; k++) begin
                case (md)
                    0:       m_frame.push_back((k == 0) ? s : 0);
                    2:       m_frame.push_back(wrap(longint'(m_last) + longint'(k) * stp));
                    default: m_frame.push_back(s);
                endcase
            end
            m_last = s;
        end else if (ei) begin
            if (m_pend.size() > 0) begin
                os = 1'b1;
                m_pend.delete();
            end
            m_pend.push_back(d);
        end
        m_und = us | (m_und & ~c);
        m_ovr = os | (m_ovr & ~c);
        if (e) begin
            x.val = m_frame.pop_front();
            x.und = m_und;
            x.ovr = m_ovr;
            exp_q.push_back(x);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        nchecks++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // one clock cycle of stimulus; the model sees the same inputs as the edge
    task automatic cyc(input bit e, input bit ei, input int d, input bit c);
        bit eg;
        eg       = e & ~reset;
        en48k    = eg;
        endatain = ei;
        datain   = DW'(d);
        clrflags = c;
        model_edge(reset, eg, ei, d, c, int'(Nfreq), int'(mode));
        @(posedge clock);
        #1;
        en48k    = 1'b0;
        endatain = 1'b0;
        clrflags = 1'b0;
        datain   = '0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            cyc(1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;
    endtask

    exp_t mon_x;
    int   mon_got;

    // monitor: every output pulse is matched against the next expected sample
    initial begin
        forever begin
            @(negedge clock);
            if (endataout === 1'b1) begin
                nchecks++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL spurious_pulse: got endataout=1 expected no output");
                end else begin
                    mon_x   = exp_q.pop_front();
                    mon_got = int'($signed(dataout));
                    if (mon_got != mon_x.val || underrun !== mon_x.und || overrun !== mon_x.ovr) begin
                        nerr++;
                        $display("FAIL output: got data=%0d und=%0b ovr=%0b expected data=%0d und=%0b ovr=%0b",
                                 mon_got, underrun, overrun, mon_x.val, mon_x.und, mon_x.ovr);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nc;
        int din;
        reset    = 1'b1;
        Nfreq    = '0;
        mode     = 2'd0;
        datain   = '0;
        endatain = 1'b0;
        en48k    = 1'b0;
        clrflags = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;

        chk("rst_dataout",   int'($signed(dataout)), 0);
        chk("rst_endataout", int'(endataout), 0);
        chk("rst_underrun",  int'(underrun), 0);
        chk("rst_overrun",   int'(overrun), 0);

        // hold, N=4
        mode = 2'd1; Nfreq = 4'd4;
        cyc(1'b0, 1'b1, 100, 1'b0); ticks(4);
        cyc(1'b0, 1'b1, 200, 1'b0); ticks(4);

        // zero-stuff, N=3
        mode = 2'd0; Nfreq = 4'd3;
        cyc(1'b0, 1'b1, 7, 1'b0);  ticks(3);
        cyc(1'b0, 1'b1, -5, 1'b0); ticks(3);
        chk("zs_underrun", int'(underrun), 0);
        chk("zs_overrun",  int'(overrun), 0);

        // linear, N=4 then N=3 from L=0
        do_reset();
        mode = 2'd2; Nfreq = 4'd4;
        cyc(1'b0, 1'b1, 400, 1'b0); ticks(4);
        cyc(1'b0, 1'b1, 400, 1'b0); ticks(4);
        do_reset();
        Nfreq = 4'd3;
        cyc(1'b0, 1'b1, -300, 1'b0); ticks(3);

        // underrun and clear
        do_reset();
        mode = 2'd1; Nfreq = 4'd2;
        cyc(1'b0, 1'b1, 50, 1'b0); ticks(3);
        chk("ur_set", int'(underrun), 1);
        ticks(1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("ur_clear", int'(underrun), 0);

        // overrun, bypass, set-over-clear priority
        do_reset();
        mode = 2'd1; Nfreq = 4'd2;
        cyc(1'b0, 1'b1, 10, 1'b0);
        cyc(1'b0, 1'b1, 20, 1'b0);
        chk("ovr_set", int'(overrun), 1);
        ticks(2);
        cyc(1'b1, 1'b1, 33, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        chk("bypass_no_underrun", int'(underrun), 0);
        ticks(1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("ovr_cleared", int'(overrun), 0);
        cyc(1'b0, 1'b1, 40, 1'b0);
        cyc(1'b0, 1'b1, 41, 1'b1);
        chk("set_beats_clear", int'(overrun), 1);
        ticks(2);

        // Nfreq=0 acts as N=1, back-to-back ticks
        Nfreq = 4'd0;
        cyc(1'b1, 1'b1, 5, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 6, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);

        // reset mid-frame with a pending sample
        do_reset();
        mode = 2'd1; Nfreq = 4'd8;
        cyc(1'b0, 1'b1, 77, 1'b0); ticks(4);
        cyc(1'b0, 1'b1, 99, 1'b0);
        do_reset();
        chk("mid_rst_dataout",   int'($signed(dataout)), 0);
        chk("mid_rst_endataout", int'(endataout), 0);
        chk("mid_rst_underrun",  int'(underrun), 0);
        chk("mid_rst_overrun",   int'(overrun), 0);
        ticks(8);
        chk("mid_rst_underrun_after", int'(underrun), 1);

        // random traffic across modes, factors and mid-frame parameter changes
        nc = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                Nfreq = CW'($urandom_range(0, 15));
                nc    = (Nfreq == 0) ? 1 : int'(Nfreq);
            end
            din = int'($urandom_range(0, 262143)) - 131072;
            if ($urandom_range(0, 3) == 0) din = din / 64;
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            cyc(($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3 * nc) == 0),
                din,
                ($urandom_range(0, 49) == 0));
            reset = 1'b0;
        end

        repeat (4) cyc(1'b0, 1'b0, 0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
